xcorr_peak_finder: RTL
======================

// Module: xcorr_peak_finder
// PURPOSE
//   Downstream of the binary-tree popcount adder in the sound source localization path.
//   The adder reports one XNOR-match count per candidate lag.
//   This block drives the lag index and sweeps all NLAG lags sequentially.
//   It keeps the running maximum and reports the argmax lag as the time-difference-of-arrival estimate.
//   It also reports a detection flag against a runtime threshold.
// PARAMETERS
//   NDATA   128  bits summed per popcount; count width CW = $clog2(NDATA)+1
//   NLAG    32   candidate lags per sweep (>=2); lag width LW = $clog2(NLAG)
// PORTS
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   request a new sweep (sampled in IDLE only)
//   thresh      in   CW  minimum peak count for a valid detection; sampled at start
//   lag_sel     out  LW  lag the upstream correlator must present on cnt
//   cnt_valid   in   1   cnt holds the popcount for lag_sel
//   cnt         in   CW  popcount from the adder
//   busy        out  1   high in SWEEP
//   done        out  1   one-cycle pulse: result registers updated
//   peak_lag    out  LW  lag with maximum count from the last completed sweep
//   peak_val    out  CW  maximum count from the last completed sweep
//   peak_found  out  1   peak_val >= thresh latched for the last sweep
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - FSM goes to IDLE.
//     - All outputs and internal registers are 0: lag_sel, busy, done, peak_*, best_val, best_lag, thr_q.
//   FSM states: IDLE, SWEEP, FINISH.
//   IDLE:
//     - cnt_valid is ignored.
//     - start=1: thr_q<=thresh, lag_sel<=0, best_val<=0, best_lag<=0, first<=1; go to SWEEP.
//   SWEEP (busy=1):
//     - start is ignored.
//     - Each cycle with cnt_valid=1 accepts one sample for the current lag_sel.
//     - Update rule: if first or cnt > best_val, then best_val<=cnt, best_lag<=lag_sel.
//     - first<=0 after the first accepted sample.
//     - Strict '>' means ties keep the lowest lag.
//     - Only the first sample may replace an equal best, so an all-zero sweep yields lag 0.
//     - Accepting a sample with lag_sel<NLAG-1 increments lag_sel by 1.
//     - lag_sel changes only on acceptance; it is stable while cnt_valid=0 (upstream stall).
//     - Accepting at lag_sel==NLAG-1 goes to FINISH; lag_sel wraps to 0.
//   FINISH (one cycle, busy=0):
//     - Candidate = final best, including the last sample's compare.
//     - peak_lag<=best_lag, peak_val<=best_val.
//     - peak_found<=(best_val>=thr_q).
//     - done=1 this cycle only; next state IDLE.
//   Latency:
//     - done is high exactly 1 cycle after the NLAG-th accepted sample.
//     - Minimum sweep is NLAG+1 cycles from the start cycle to done.
//     - start seen in the FINISH cycle is ignored; it is accepted from IDLE on the following cycle.
//   Results hold their values until the next FINISH; a new sweep does not clear them.
//   Width rules:
//     - All compares are unsigned CW-bit.
//     - cnt max = NDATA fits CW bits; no saturation is needed.
//   rst_n low mid-sweep:
//     - Abort immediately, no done pulse; result registers are reset to 0.
// TESTING
//   1. Reset: assert rst_n=0 mid-SWEEP.
//      -> all outputs 0 at once; no done; idle after release.
//   2. Single peak: NLAG=32, cnt=lag==9 ? 100 : 40, cnt_valid always 1, thresh=64.
//      -> done 33 cycles after start; peak_lag=9, peak_val=100, peak_found=1.
//   3. Tie and last lag:
//      - counts 70 at lags 3 and 17, else 10 -> peak_lag=3.
//      - repeat with 90 at lag 31 only -> peak_lag=31, peak_val=90.
//   4. Threshold: all counts 50, thresh=51.
//      -> peak_lag=0, peak_val=50, peak_found=0.
//      - repeat with thresh=50 -> peak_found=1.
//   5. Stall: random cnt_valid gaps, with cnt deliberately wrong while invalid.
//      -> lag_sel steps only on valid; result equals the no-stall reference model.
//   6. Protocol: start pulsed during SWEEP and in the FINISH cycle.
//      -> no restart; peak_* held until next done; a second sweep runs back-to-back correctly.

Source files
------------

// File: rtl/xcorr_peak_finder.sv
// xcorr_peak_finder: sweeps all candidate lags, tracks the running maximum
// popcount and reports the argmax lag plus a threshold detection flag.
module xcorr_peak_finder #(
  parameter  int unsigned NDATA = 128,
  parameter  int unsigned NLAG  = 32,
  localparam int unsigned CW    = $clog2(NDATA) + 1,
  localparam int unsigned LW    = $clog2(NLAG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] thresh,
  output logic [LW-1:0] lag_sel,
  input  logic          cnt_valid,
  input  logic [CW-1:0] cnt,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] peak_lag,
  output logic [CW-1:0] peak_val,
  output logic          peak_found
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [LW-1:0] LAST_LAG = LW'(NLAG - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] lag_q, lag_d;
  logic [CW-1:0] best_val_q, best_val_d;
  logic [LW-1:0] best_lag_q, best_lag_d;
  logic          first_q, first_d;
  logic [CW-1:0] thr_q, thr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [LW-1:0] peak_lag_q, peak_lag_d;
  logic [CW-1:0] peak_val_q, peak_val_d;
  logic          peak_found_q, peak_found_d;

  logic          take_c;
  logic [CW-1:0] cand_val_c;
  logic [LW-1:0] cand_lag_c;

  // Candidate best after folding in the current sample; strict '>' keeps the lowest lag on ties.
  always_comb begin
    take_c     = first_q || (cnt > best_val_q);
    cand_val_c = take_c ? cnt : best_val_q;
    cand_lag_c = take_c ? lag_q : best_lag_q;
  end

  // Next-state and register-input logic for the sweep controller.
  always_comb begin
    state_d      = state_q;
    lag_d        = lag_q;
    best_val_d   = best_val_q;
    best_lag_d   = best_lag_q;
    first_d      = first_q;
    thr_d        = thr_q;
    peak_lag_d   = peak_lag_q;
    peak_val_d   = peak_val_q;
    peak_found_d = peak_found_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          thr_d      = thresh;
          lag_d      = '0;
          best_val_d = '0;
          best_lag_d = '0;
          first_d    = 1'b1;
          state_d    = SWEEP;
        end
      end
      SWEEP: begin
        if (cnt_valid) begin
          best_val_d = cand_val_c;
          best_lag_d = cand_lag_c;
          first_d    = 1'b0;
          if (lag_q == LAST_LAG) begin
            // Results are loaded on entry to FINISH so they are visible while done is high.
            lag_d        = '0;
            peak_lag_d   = cand_lag_c;
            peak_val_d   = cand_val_c;
            peak_found_d = (cand_val_c >= thr_q);
            state_d      = FINISH;
          end else begin
            lag_d = lag_q + LW'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SWEEP);
    done_d = (state_d == FINISH);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lag_q        <= '0;
      best_val_q   <= '0;
      best_lag_q   <= '0;
      first_q      <= 1'b0;
      thr_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      peak_lag_q   <= '0;
      peak_val_q   <= '0;
      peak_found_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lag_q        <= lag_d;
      best_val_q   <= best_val_d;
      best_lag_q   <= best_lag_d;
      first_q      <= first_d;
      thr_q        <= thr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      peak_lag_q   <= peak_lag_d;
      peak_val_q   <= peak_val_d;
      peak_found_q <= peak_found_d;
    end
  end

  assign lag_sel    = lag_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign peak_lag   = peak_lag_q;
  assign peak_val   = peak_val_q;
  assign peak_found = peak_found_q;

endmodule
